// File: rtl/axi_lite_reg_arbiter.sv
// rtl/axi_lite_reg_arbiter.sv - two-client round-robin AXI4-Lite master for a shared register port
module axi_lite_reg_arbiter #(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic [1:0]                req_valid,
  input  logic [1:0]                req_write,
  input  logic [2*ADDR_WIDTH-1:0]   req_addr,
  input  logic [2*DATA_WIDTH-1:0]   req_wdata,
  output logic [1:0]                req_ready,
  output logic [1:0]                rsp_valid,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic                      timeout_err,
  output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [2:0]                m_axi_awprot,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic [2:0]                m_axi_arprot,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TIMEOUT_VAL = CW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_WR_RESP,
    S_RD_ADDR,
    S_RD_DATA,
    S_RESPOND
  } state_t;

  state_t                  state_q, state_d;
  logic                    last_grant_q, last_grant_d;
  logic                    grant_q, grant_d;
  logic                    write_q, write_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              resp_q, resp_d;
  logic [CW-1:0]           wait_cnt_q, wait_cnt_d;
  logic                    timeout_err_q, timeout_err_d;

  logic                    grant_sel;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic [CW-1:0]           wait_cnt_inc;
  logic                    waiting;

  // AXI channel outputs are decoded straight from state so reset drops them at once
  assign m_axi_awvalid = (state_q == S_WRITE) && !aw_done_q;
  assign m_axi_wvalid  = (state_q == S_WRITE) && !w_done_q;
  assign m_axi_bready  = (state_q == S_WR_RESP);
  assign m_axi_arvalid = (state_q == S_RD_ADDR);
  assign m_axi_rready  = (state_q == S_RD_DATA);
  assign m_axi_awaddr  = addr_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = '1;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_arprot  = 3'b000;
  assign rsp_valid     = (state_q == S_RESPOND) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = resp_q;
  assign timeout_err   = timeout_err_q;

  assign waiting      = (state_q == S_WRITE) || (state_q == S_WR_RESP) ||
                        (state_q == S_RD_ADDR) || (state_q == S_RD_DATA);
  assign wait_cnt_inc = (wait_cnt_q == TIMEOUT_VAL) ? wait_cnt_q : wait_cnt_q + 1'b1;

  // Next-state logic: round-robin grant in IDLE, then walk one AXI transaction to completion
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    grant_d       = grant_q;
    write_d       = write_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    rdata_d       = rdata_q;
    resp_d        = resp_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q;
    req_ready     = 2'b00;
    grant_sel     = 1'b0;
    sel_addr      = '0;
    sel_wdata     = '0;

    case (state_q)
      S_IDLE: begin
        if (ARESETN && (req_valid != 2'b00)) begin
          // On a tie the requester that did not win last time goes first
          if (req_valid == 2'b11) grant_sel = ~last_grant_q;
          else                    grant_sel = req_valid[1];
          sel_addr  = grant_sel ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
          sel_wdata = grant_sel ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
          req_ready[grant_sel] = 1'b1;
          grant_d      = grant_sel;
          last_grant_d = grant_sel;
          write_d      = req_write[grant_sel];
          addr_d       = {sel_addr[ADDR_WIDTH-1:2], 2'b00};
          wdata_d      = sel_wdata;
          aw_done_d    = 1'b0;
          w_done_d     = 1'b0;
          rdata_d      = '0;
          resp_d       = 2'b00;
          state_d      = req_write[grant_sel] ? S_WRITE : S_RD_ADDR;
        end
      end
      S_WRITE: begin
        wait_cnt_d = wait_cnt_inc;
        aw_done_d  = aw_done_q | (m_axi_awvalid & m_axi_awready);
        w_done_d   = w_done_q | (m_axi_wvalid & m_axi_wready);
        if (aw_done_d && w_done_d) state_d = S_WR_RESP;
      end
      S_WR_RESP: begin
        wait_cnt_d = wait_cnt_inc;
        if (m_axi_bvalid) begin
          resp_d     = m_axi_bresp;
          wait_cnt_d = '0;
          state_d    = S_RESPOND;
        end
      end
      S_RD_ADDR: begin
        wait_cnt_d = wait_cnt_inc;
        if (m_axi_arready) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        wait_cnt_d = wait_cnt_inc;
        if (m_axi_rvalid) begin
          rdata_d    = m_axi_rdata;
          resp_d     = m_axi_rresp;
          wait_cnt_d = '0;
          state_d    = S_RESPOND;
        end
      end
      S_RESPOND: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Stuck-bus flag only; the transaction keeps waiting on the slave
    if (waiting && (wait_cnt_inc == TIMEOUT_VAL)) timeout_err_d = 1'b1;
  end

  // State and datapath registers
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q       <= S_IDLE;
      last_grant_q  <= 1'b1;
      grant_q       <= 1'b0;
      write_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      rdata_q       <= '0;
      resp_q        <= 2'b00;
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      grant_q       <= grant_d;
      write_q       <= write_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
      rdata_q       <= rdata_d;
      resp_q        <= resp_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_reg_arbiter.sv
// tb/tb_axi_lite_reg_arbiter.sv - directed self-checking bench for axi_lite_reg_arbiter
module tb_axi_lite_reg_arbiter;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int TO = 8;

  logic            ACLK = 1'b0;
  logic            ARESETN = 1'b0;
  logic [1:0]      req_valid = 2'b00;
  logic [1:0]      req_write = 2'b00;
  logic [2*AW-1:0] req_addr = '0;
  logic [2*DW-1:0] req_wdata = '0;
  logic [1:0]      req_ready, rsp_valid, rsp_resp;
  logic [DW-1:0]   rsp_rdata;
  logic            timeout_err;
  logic [AW-1:0]   m_axi_awaddr, m_axi_araddr;
  logic [2:0]      m_axi_awprot, m_axi_arprot;
  logic            m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
  logic [DW-1:0]   m_axi_wdata;
  logic [DW/8-1:0] m_axi_wstrb;
  logic            m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_arready, m_axi_rvalid;
  logic [1:0]      m_axi_bresp, m_axi_rresp;
  logic [DW-1:0]   m_axi_rdata;

  int errors = 0;
  int checks = 0;

  // slave knobs, written only by the main sequence
  int aw_delay = 0;
  bit ar_block = 0;
  bit b_hold = 0;
  bit slave_rst = 0;

  // slave state and monitors, written only by the slave process
  logic [31:0] mem [4];
  bit have_aw, have_w, have_ar;
  bit aw_hs_p, w_hs_p, b_hs_p, ar_hs_p, r_hs_p;
  logic [3:0]  aw_addr_s, ar_addr_s, last_awaddr, last_araddr;
  logic [31:0] w_data_s, last_wdata;
  logic [3:0]  last_wstrb;
  int aw_seen, aw_hi_cnt, w_hi_cnt, b_beats;

  axi_lite_reg_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .timeout_err(timeout_err),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  always #5 ACLK = ~ACLK;

  // Register-file slave: acts on falling edges, handshakes complete on the next rising edge
  initial begin
    for (int i = 0; i < 4; i++) mem[i] = '0;
    {have_aw, have_w, have_ar, aw_hs_p, w_hs_p, b_hs_p, ar_hs_p, r_hs_p} = '0;
    {aw_addr_s, ar_addr_s, last_awaddr, last_araddr, last_wstrb} = '0;
    {w_data_s, last_wdata} = '0;
    aw_seen = 0; aw_hi_cnt = 0; w_hi_cnt = 0; b_beats = 0;
    {m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_arready, m_axi_rvalid} = '0;
    m_axi_bresp = 2'b00; m_axi_rresp = 2'b00; m_axi_rdata = '0;
    forever begin
      @(negedge ACLK);
      if (slave_rst) begin
        {have_aw, have_w, have_ar, aw_hs_p, w_hs_p, b_hs_p, ar_hs_p, r_hs_p} = '0;
        {m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_arready, m_axi_rvalid} = '0;
        aw_seen = 0;
      end else begin
        if (aw_hs_p) begin have_aw = 1; aw_addr_s = last_awaddr; end
        if (w_hs_p)  begin have_w = 1;  w_data_s = last_wdata; end
        if (ar_hs_p) begin have_ar = 1; ar_addr_s = last_araddr; end
        if (b_hs_p) m_axi_bvalid = 0;
        if (r_hs_p) m_axi_rvalid = 0;
        if (have_aw && have_w && !m_axi_bvalid && !b_hold) begin
          mem[aw_addr_s[3:2]] = w_data_s;
          m_axi_bvalid = 1; m_axi_bresp = 2'b00;
          have_aw = 0; have_w = 0;
        end
        if (have_ar && !m_axi_rvalid) begin
          m_axi_rvalid = 1; m_axi_rdata = mem[ar_addr_s[3:2]]; m_axi_rresp = 2'b00;
          have_ar = 0;
        end
        if (m_axi_awvalid) begin
          m_axi_awready = (aw_seen >= aw_delay);
          aw_seen++; aw_hi_cnt++;
        end else m_axi_awready = 0;
        m_axi_wready  = m_axi_wvalid;
        if (m_axi_wvalid) w_hi_cnt++;
        m_axi_arready = m_axi_arvalid && !ar_block;
        aw_hs_p = m_axi_awvalid && m_axi_awready;
        w_hs_p  = m_axi_wvalid && m_axi_wready;
        b_hs_p  = m_axi_bvalid && m_axi_bready;
        ar_hs_p = m_axi_arvalid && m_axi_arready;
        r_hs_p  = m_axi_rvalid && m_axi_rready;
        if (aw_hs_p) begin last_awaddr = m_axi_awaddr; aw_seen = 0; end
        if (w_hs_p)  begin last_wdata = m_axi_wdata; last_wstrb = m_axi_wstrb; end
        if (ar_hs_p) last_araddr = m_axi_araddr;
        if (b_hs_p)  b_beats++;
      end
    end
  end

  task automatic pulse_reset();
    @(negedge ACLK);
    ARESETN = 0; slave_rst = 1; req_valid = 2'b00;
    repeat (2) @(posedge ACLK);
    @(negedge ACLK); ARESETN = 1;
    @(negedge ACLK); slave_rst = 0;
  endtask

  // One request from one client; reports response, grant-to-response latency in cycles
  task automatic xact(input int who, input bit wr, input logic [3:0] addr, input logic [31:0] wd,
                      output logic [31:0] rd, output logic [1:0] rs, output int lat,
                      output bit ok, output bit one_pulse);
    bit granted; int gcyc;
    granted = 0; gcyc = 0; ok = 0; lat = -1; rd = '0; rs = 2'b11; one_pulse = 0;
    @(posedge ACLK); #1;
    req_write[who] = wr;
    req_addr[who*AW +: AW] = addr;
    req_wdata[who*DW +: DW] = wd;
    req_valid[who] = 1'b1;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge ACLK);
      if (granted && rsp_valid[who]) begin rd = rsp_rdata; rs = rsp_resp; lat = c - gcyc; ok = 1; end
      if (!granted && req_ready[who]) begin granted = 1; gcyc = c; end
      @(posedge ACLK); #1;
      if (granted) req_valid[who] = 1'b0;
    end
    req_valid[who] = 1'b0;
    @(negedge ACLK);
    one_pulse = ok && !rsp_valid[who];
  endtask

  task automatic test_reset();
    repeat (2) @(posedge ACLK);
    @(negedge ACLK); #1;
    checks++;
    if ({req_ready, rsp_valid, timeout_err, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
         m_axi_arvalid, m_axi_rready} !== 12'h0)
      begin errors++; $display("FAIL reset_ctrl got %b expected 0", {req_ready, rsp_valid, timeout_err,
        m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}); end
    checks++;
    if ({m_axi_awaddr, m_axi_araddr, m_axi_awprot, m_axi_arprot, m_axi_wdata, rsp_rdata, rsp_resp} !== '0)
      begin errors++; $display("FAIL reset_data got %h/%h/%h/%h expected 0", m_axi_awaddr, m_axi_araddr,
        m_axi_wdata, rsp_rdata); end
    @(negedge ACLK); ARESETN = 1;
    repeat (2) @(negedge ACLK);
    checks++;
    if ({req_ready, rsp_valid, timeout_err, m_axi_awvalid, m_axi_arvalid} !== 7'h0)
      begin errors++; $display("FAIL idle_after_reset got %b expected 0",
        {req_ready, rsp_valid, timeout_err, m_axi_awvalid, m_axi_arvalid}); end
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic [1:0] rs; int lat; bit ok, op;
    xact(0, 1, 4'h0, 32'h0000_0001, rd, rs, lat, ok, op);
    checks++; if (!ok) begin errors++; $display("FAIL wr0_done got timeout expected response"); end
    checks++; if (last_awaddr !== 4'h0 || last_wdata !== 32'h1)
      begin errors++; $display("FAIL wr0_aw_w got %h/%h expected 0/00000001", last_awaddr, last_wdata); end
    checks++; if (last_wstrb !== 4'hF) begin errors++; $display("FAIL wr0_wstrb got %h expected f", last_wstrb); end
    checks++; if (rs !== 2'b00 || rd !== 32'h0)
      begin errors++; $display("FAIL wr0_rsp got resp %b rdata %h expected 00/0", rs, rd); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL wr0_latency got %0d expected 3", lat); end
    checks++; if (!op) begin errors++; $display("FAIL wr0_pulse got multi-cycle expected one cycle"); end
    xact(1, 0, 4'h0, 32'h0, rd, rs, lat, ok, op);
    checks++; if (!ok || rd !== 32'h1 || rs !== 2'b00)
      begin errors++; $display("FAIL rd1_data got %h resp %b expected 00000001/00", rd, rs); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL rd1_latency got %0d expected 3", lat); end
    xact(1, 1, 4'h7, 32'h1234_5678, rd, rs, lat, ok, op);
    checks++; if (!ok || last_awaddr !== 4'h4)
      begin errors++; $display("FAIL wr_unaligned got awaddr %h expected 4", last_awaddr); end
    xact(0, 0, 4'hB, 32'h0, rd, rs, lat, ok, op);
    checks++; if (!ok || last_araddr !== 4'h8)
      begin errors++; $display("FAIL rd_unaligned got araddr %h expected 8", last_araddr); end
  endtask

  task automatic test_fill();
    logic [31:0] rd; logic [1:0] rs; int lat; bit ok, op;
    for (int i = 0; i < 4; i++) begin
      xact(0, 1, 4'(4*i), 32'(i+1), rd, rs, lat, ok, op);
      checks++; if (!ok || rs !== 2'b00)
        begin errors++; $display("FAIL fill_wr%0d got ok=%0d resp %b expected 1/00", i, ok, rs); end
    end
    for (int i = 0; i < 4; i++) begin
      xact(0, 0, 4'(4*i), 32'h0, rd, rs, lat, ok, op);
      checks++; if (!ok || rd !== 32'(i+1) || rs !== 2'b00)
        begin errors++; $display("FAIL fill_rd%0d got %h resp %b expected %h/00", i, rd, rs, 32'(i+1)); end
    end
  endtask

  task automatic test_conflict();
    int gnt[$]; int rsp[$]; logic [31:0] rdv [2]; bit drop [2]; int gord, rord;
    pulse_reset();
    for (int round = 0; round < 2; round++) begin
      gnt.delete(); rsp.delete(); rdv[0] = '0; rdv[1] = '0;
      @(posedge ACLK); #1;
      req_write = 2'b00; req_addr = {4'h8, 4'h4}; req_valid = 2'b11;
      for (int c = 0; c < 100 && rsp.size() < 2; c++) begin
        @(negedge ACLK);
        drop[0] = 0; drop[1] = 0;
        for (int i = 0; i < 2; i++) begin
          if (rsp_valid[i]) begin rsp.push_back(i); rdv[i] = rsp_rdata; end
          if (req_ready[i]) begin gnt.push_back(i); drop[i] = 1; end
        end
        @(posedge ACLK); #1;
        for (int i = 0; i < 2; i++) if (drop[i]) req_valid[i] = 1'b0;
      end
      req_valid = 2'b00;
      gord = (gnt.size() > 0 ? gnt[0] : 9) * 10 + (gnt.size() > 1 ? gnt[1] : 9);
      rord = (rsp.size() > 0 ? rsp[0] : 9) * 10 + (rsp.size() > 1 ? rsp[1] : 9);
      checks++; if (gord != 1 || gnt.size() != 2)
        begin errors++; $display("FAIL conflict%0d_grant got order %0d expected 1 (req0 then req1)", round, gord); end
      checks++; if (rord != 1)
        begin errors++; $display("FAIL conflict%0d_rsp got order %0d expected 1", round, rord); end
      checks++; if (rdv[0] !== 32'h2 || rdv[1] !== 32'h3)
        begin errors++; $display("FAIL conflict%0d_data got %h/%h expected 2/3", round, rdv[0], rdv[1]); end
    end
  endtask

  task automatic test_skew_write();
    logic [31:0] rd; logic [1:0] rs; int lat; bit ok, op; int aw0, w0, b0;
    aw_delay = 3;
    aw0 = aw_hi_cnt; w0 = w_hi_cnt; b0 = b_beats;
    xact(1, 1, 4'hC, 32'hA5A5_5A5A, rd, rs, lat, ok, op);
    aw_delay = 0;
    checks++; if (!ok || rs !== 2'b00) begin errors++; $display("FAIL skew_done got ok=%0d resp %b expected 1/00", ok, rs); end
    checks++; if (aw_hi_cnt - aw0 != 4)
      begin errors++; $display("FAIL skew_awvalid got %0d cycles expected 4", aw_hi_cnt - aw0); end
    checks++; if (w_hi_cnt - w0 != 1)
      begin errors++; $display("FAIL skew_wvalid got %0d cycles expected 1", w_hi_cnt - w0); end
    checks++; if (b_beats - b0 != 1)
      begin errors++; $display("FAIL skew_bbeats got %0d expected 1", b_beats - b0); end
    checks++; if (lat !== 6) begin errors++; $display("FAIL skew_latency got %0d expected 6", lat); end
    xact(0, 0, 4'hC, 32'h0, rd, rs, lat, ok, op);
    checks++; if (!ok || rd !== 32'hA5A5_5A5A)
      begin errors++; $display("FAIL skew_readback got %h expected a5a55a5a", rd); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL skew_no_timeout got %b expected 0", timeout_err); end
  endtask

  task automatic test_timeout();
    bit granted; logic err8, err9, arv9; bit held_ok, rdy_seen;
    ar_block = 1; granted = 0; held_ok = 1; rdy_seen = 0; err8 = 1'bx;
    @(posedge ACLK); #1;
    req_write[0] = 1'b0; req_addr[AW-1:0] = 4'h4; req_valid[0] = 1'b1;
    for (int c = 0; c < 20 && !granted; c++) begin
      @(negedge ACLK);
      if (req_ready[0]) granted = 1;
      @(posedge ACLK); #1;
    end
    req_valid[0] = 1'b0;
    checks++; if (!granted) begin errors++; $display("FAIL timeout_grant got none expected grant"); end
    // wait cycle k is observed at the k-th falling edge after the grant edge
    for (int k = 1; k <= 8; k++) begin
      @(negedge ACLK);
      if (k == 8) err8 = timeout_err;
    end
    @(negedge ACLK);
    err9 = timeout_err; arv9 = m_axi_arvalid;
    checks++; if (err8 !== 1'b0) begin errors++; $display("FAIL timeout_early got %b during wait cycle 8 expected 0", err8); end
    checks++; if (err9 !== 1'b1 || arv9 !== 1'b1)
      begin errors++; $display("FAIL timeout_set got err %b arvalid %b expected 1/1", err9, arv9); end
    req_write[1] = 1'b1; req_valid[1] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge ACLK);
      if (m_axi_arvalid !== 1'b1 || timeout_err !== 1'b1) held_ok = 0;
      if (req_ready[1] !== 1'b0) rdy_seen = 1;
    end
    req_valid[1] = 1'b0;
    checks++; if (!held_ok) begin errors++; $display("FAIL timeout_hold got arvalid/err dropped expected held"); end
    checks++; if (rdy_seen) begin errors++; $display("FAIL busy_holdoff got req_ready 1 expected 0"); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic [1:0] rs; int lat; bit ok, op, granted, inresp, spurious;
    pulse_reset();
    ar_block = 0;
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_clears_timeout got %b expected 0", timeout_err); end
    b_hold = 1; granted = 0; inresp = 0; spurious = 0;
    @(posedge ACLK); #1;
    req_write[0] = 1'b1; req_addr[AW-1:0] = 4'h0; req_wdata[DW-1:0] = 32'hDEAD_BEEF; req_valid[0] = 1'b1;
    for (int c = 0; c < 30 && !inresp; c++) begin
      @(negedge ACLK);
      if (granted && m_axi_bready) inresp = 1;
      if (req_ready[0]) granted = 1;
      if (!inresp) begin @(posedge ACLK); #1; if (granted) req_valid[0] = 1'b0; end
    end
    req_valid[0] = 1'b0;
    checks++; if (!inresp) begin errors++; $display("FAIL mid_reach_wr_resp got none expected bready"); end
    #1; ARESETN = 0; slave_rst = 1; #1;
    checks++;
    if ({req_ready, rsp_valid, timeout_err, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
         m_axi_arvalid, m_axi_rready} !== 12'h0 || m_axi_wdata !== '0 || m_axi_awaddr !== '0)
      begin errors++; $display("FAIL mid_reset_outputs got bready %b wdata %h expected 0/0", m_axi_bready, m_axi_wdata); end
    repeat (2) @(posedge ACLK);
    @(negedge ACLK); ARESETN = 1;
    @(negedge ACLK); slave_rst = 0; b_hold = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge ACLK);
      if (rsp_valid !== 2'b00) spurious = 1;
    end
    checks++; if (spurious) begin errors++; $display("FAIL mid_no_response got rsp_valid pulse expected none"); end
    xact(1, 0, 4'h0, 32'h0, rd, rs, lat, ok, op);
    checks++; if (!ok || rd !== 32'h1 || rs !== 2'b00)
      begin errors++; $display("FAIL mid_recover_read got ok=%0d %h resp %b expected 1/00000001/00", ok, rd, rs); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_fill();
    test_conflict();
    test_skew_write();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish expected finish");
    $fatal(1);
  end

endmodule
